instr_fetch: RTL and testbench

- Instruction fetch stage that sits directly upstream of the 5-stage pipeline core.
- Generates sequential fetch addresses and issues them to instruction memory over a valid/ready request channel.
- Accepts in-order responses and buffers {pc, instr} pairs in a small FIFO.
- Presents them to decode with a valid/ready handshake, and supports a single-cycle redirect (branch/jump) that flushes all in-flight fetches.

---
 rtl/cpu_pkg.sv | 10 +
 rtl/fetch_fifo.sv | 45 ++++
 rtl/instr_fetch.sv | 73 +++++++
 tb/tb_instr_fetch.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared core-wide widths, reset vector, NOP encoding and fetch entry type
package cpu_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small circular buffer of fetched entries with flush
// Ports: clk, rst_n (async active-low); push/push_data write the tail; pop advances the head;
// flush empties the buffer; count/empty/full report occupancy; head is the oldest entry.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter type T = logic [63:0]
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  T                         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output T                         head
);
  localparam int AW = $clog2(DEPTH);
  T mem [DEPTH];
  logic [AW-1:0] rd, wr;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign head = mem[rd];
  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else if (flush) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wr] <= push_data;
        wr <= wr + 1'b1;
      end
      if (pop) rd <= rd + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: sequential fetch address generation, in-order response buffering and redirect flush
// Ports: clk, rst_n (async active-low); imem_req_* issues word addresses with valid/ready;
// imem_resp_* returns in-order instructions; redirect_* retargets fetch and flushes;
// id_* presents {pc, instr} to decode with valid/ready.
module instr_fetch #(
  parameter int XLEN = cpu_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = cpu_pkg::RESET_PC_DEFAULT,
  parameter int FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc
);
  import cpu_pkg::*;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [XLEN-1:0] fetch_pc, resp_pc, redirect_tgt;
  logic [CW-1:0] outstanding, drop_cnt, fifo_count;
  logic fifo_empty, fifo_full, req_fire, resp_drop, push, pop;
  fetch_entry_t head;
  assign redirect_tgt = redirect_pc & ~XLEN'(3);
  // Only issue when every in-flight response is guaranteed a FIFO slot.
  assign imem_req_valid = rst_n && !redirect_valid && drop_cnt == '0
                          && (outstanding + fifo_count < CW'(FIFO_DEPTH));
  assign imem_req_addr = fetch_pc;
  assign req_fire = imem_req_valid && imem_req_ready;
  assign resp_drop = imem_resp_valid && drop_cnt != '0;
  assign push = imem_resp_valid && drop_cnt == '0 && !redirect_valid;
  assign id_valid = rst_n && !fifo_empty && !redirect_valid;
  assign pop = id_valid && id_ready;
  assign id_instr = head.instr;
  assign id_pc = head.pc;
  fetch_fifo #(.DEPTH(FIFO_DEPTH), .T(fetch_entry_t)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push && (!fifo_full || pop)),
    .push_data('{pc: resp_pc, instr: imem_resp_data}),
    .pop(pop),
    .flush(redirect_valid),
    .count(fifo_count),
    .empty(fifo_empty),
    .full(fifo_full),
    .head(head)
  );
  // Responses still owed to the old stream accumulate in drop_cnt across back-to-back redirects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      resp_pc <= RESET_PC;
      outstanding <= '0;
      drop_cnt <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_tgt;
      resp_pc <= redirect_tgt;
      drop_cnt <= drop_cnt + outstanding - CW'(imem_resp_valid);
      outstanding <= '0;
    end else begin
      fetch_pc <= req_fire ? fetch_pc + XLEN'(4) : fetch_pc;
      resp_pc <= push ? resp_pc + XLEN'(4) : resp_pc;
      outstanding <= outstanding + CW'(req_fire) - CW'(push);
      drop_cnt <= drop_cnt - CW'(resp_drop);
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed checks of fetch ordering, credit stall, redirect drop and async reset
module tb_instr_fetch;
  localparam logic [31:0] K = 32'hA5A5_0000;
  logic clk = 0, rst_n = 0, imem_req_ready = 0, imem_resp_valid = 0, redirect_valid = 0, id_ready = 0;
  logic [31:0] imem_resp_data = 0, redirect_pc = 0;
  logic imem_req_valid, id_valid;
  logic [31:0] imem_req_addr, id_instr, id_pc;
  always #5 clk = ~clk;
  instr_fetch dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .id_valid(id_valid),
    .id_ready(id_ready),
    .id_instr(id_instr),
    .id_pc(id_pc)
  );
  typedef struct {logic [31:0] a; int due;} mem_t;
  mem_t pend[$];
  int total = 0, passed = 0, lat = 1, cyc = 0, fires = 0, pops = 0, first_v = -1;
  logic [31:0] exp_req = 0, exp_pc = 0;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic step();
    logic f, r, p;
    logic [31:0] a;
    #1;
    f = imem_req_valid && imem_req_ready;
    a = imem_req_addr;
    r = imem_resp_valid;
    p = id_valid && id_ready;
    if (id_valid && first_v < 0) first_v = cyc;
    check("no_ovf", 32'(dut.push && dut.fifo_full && !dut.pop), 0);
    if (f) begin
      check("req_addr", a, exp_req);
      exp_req += 4;
      fires++;
    end
    if (p) begin
      check("id_pc", id_pc, exp_pc);
      check("id_instr", id_instr, exp_pc ^ K);
      exp_pc += 4;
      pops++;
    end
    if (redirect_valid) begin
      exp_req = redirect_pc & ~32'h3;
      exp_pc = exp_req;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (r) void'(pend.pop_front());
    if (f) pend.push_back('{a, cyc + lat - 1});
    imem_resp_valid = 0;
    imem_resp_data = 0;
    if (pend.size() > 0) if (pend[0].due <= cyc) begin
      imem_resp_valid = 1;
      imem_resp_data = pend[0].a ^ K;
    end
  endtask
  task automatic do_reset();
    rst_n = 0;
    imem_resp_valid = 0;
    imem_resp_data = 0;
    redirect_valid = 0;
    pend.delete();
    #1;
    check("rst_req_valid", 32'(imem_req_valid), 0);
    check("rst_req_addr", imem_req_addr, 0);
    check("rst_id_valid", 32'(id_valid), 0);
    check("rst_id_pc", id_pc, 0);
    check("rst_id_instr", id_instr, 0);
    check("rst_outstanding", 32'(dut.outstanding), 0);
    check("rst_drop", 32'(dut.drop_cnt), 0);
    @(negedge clk);
    rst_n = 1;
    cyc = 0;
    fires = 0;
    pops = 0;
    first_v = -1;
    exp_req = 0;
    exp_pc = 0;
  endtask
  initial begin
    // streaming with 1-cycle memory
    do_reset();
    lat = 1; imem_req_ready = 1; id_ready = 1;
    repeat (12) step();
    check("t1_first_valid", first_v, 2);
    check("t1_pops", 32'(pops >= 6), 1);
    // decode stalled from reset: credit limit holds fetch at two requests
    do_reset();
    id_ready = 0;
    repeat (10) step();
    #1;
    check("t2_fires", fires, 2);
    check("t2_req_valid", 32'(imem_req_valid), 0);
    check("t2_fifo_count", 32'(dut.fifo_count), 2);
    id_ready = 1;
    repeat (8) step();
    check("t2_pops", 32'(pops >= 3), 1);
    check("t2_resume", 32'(fires >= 3), 1);
    // memory not ready for five cycles
    do_reset();
    imem_req_ready = 0;
    repeat (5) begin
      #1;
      check("t3_req_valid", 32'(imem_req_valid), 1);
      check("t3_req_addr", imem_req_addr, 0);
      check("t3_id_valid", 32'(id_valid), 0);
      step();
    end
    imem_req_ready = 1;
    step();
    check("t3_accept", fires, 1);
    repeat (4) step();
    // redirect with two requests outstanding, 3-cycle memory
    do_reset();
    lat = 3;
    repeat (2) step();
    #1;
    check("t4_outstanding", 32'(dut.outstanding), 2);
    redirect_valid = 1; redirect_pc = 32'h0000_0103;
    step();
    redirect_valid = 0;
    check("t4_drop", 32'(dut.drop_cnt), 2);
    pops = 0;
    repeat (12) step();
    check("t4_pops", 32'(pops >= 2), 1);
    check("t4_drop_end", 32'(dut.drop_cnt), 0);
    // back-to-back redirects, second one coincides with a stale response
    do_reset();
    repeat (2) step();
    redirect_valid = 1; redirect_pc = 32'h0000_0200;
    step();
    #1;
    check("t4b_resp", 32'(imem_resp_valid), 1);
    redirect_pc = 32'h0000_0302;
    step();
    redirect_valid = 0;
    check("t4b_drop", 32'(dut.drop_cnt), 1);
    pops = 0;
    repeat (12) step();
    check("t4b_pops", 32'(pops >= 2), 1);
    check("t4b_drop_end", 32'(dut.drop_cnt), 0);
    // redirect in the same cycle as a response and a decode pop
    do_reset();
    lat = 2;
    repeat (3) step();
    #1;
    check("t5_resp", 32'(imem_resp_valid), 1);
    check("t5_id_valid", 32'(id_valid), 1);
    redirect_valid = 1; redirect_pc = 32'h0000_0400;
    step();
    redirect_valid = 0;
    check("t5_outstanding", 32'(dut.outstanding), 0);
    check("t5_drop", 32'(dut.drop_cnt), 0);
    check("t5_no_pop", pops, 0);
    repeat (10) step();
    check("t5_pops", 32'(pops >= 2), 1);
    // asynchronous reset mid-cycle with a full FIFO
    do_reset();
    lat = 1; id_ready = 0;
    repeat (6) step();
    #1;
    check("t6_full", 32'(dut.fifo_count), 2);
    check("t6_id_valid", 32'(id_valid), 1);
    #2;
    rst_n = 0;
    #1;
    check("t6_async_id_valid", 32'(id_valid), 0);
    check("t6_async_req_valid", 32'(imem_req_valid), 0);
    do_reset();
    id_ready = 1;
    repeat (8) step();
    check("t6_restart", 32'(fires >= 2), 1);
    check("t6_restart_pops", 32'(pops >= 2), 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
